// File: rtl/instr_issue.sv
// ============================================================================
// Module   : instr_issue
// Purpose  : Circular instruction buffer feeding a three-state issue FSM that
//            decodes register-file strobes and holds each issue until acked.
// Options  : ISSUE_LOOP_EN - every popped word is rewritten at the tail.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_issue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_ins,
  input  logic        run,
  input  logic        ack,
  output logic        ins_valid,
  output logic [3:0]  opcode,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic [3:0]  dest,
  output logic        Rd1,
  output logic        Rd2,
  output logic        Wr,
  output logic [4:0]  count,
  output logic        full,
  output logic        empty,
  output logic        ovf
);

  localparam int         c_ptr_w = $clog2(DEPTH);
  localparam logic [4:0] c_depth = 5'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              r_state;
  logic [15:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [4:0]          r_count;
  logic                r_ovf;
  logic                r_valid;
  logic                r_rd1;
  logic                r_rd2;
  logic                r_wr;
  logic [15:0]         r_ins;

  logic [15:0]         w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_reject;
  logic                w_consume;
  logic                w_mem_we;
  logic [15:0]         w_mem_wdata;
  logic [2:0]          w_dec;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == 5'd0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_pop   = (r_state == S_IDLE) && run && !w_empty;

`ifdef ISSUE_LOOP_EN
  // The tail slot is taken by the recirculated word, so a pop blocks pushes.
  assign w_push      = load && !w_full && !w_pop;
  assign w_reject    = load && (w_full || w_pop);
  assign w_consume   = 1'b0;
  assign w_mem_we    = w_push || w_pop;
  assign w_mem_wdata = w_pop ? w_head : load_ins;
`else
  assign w_push      = load && !w_full;
  assign w_reject    = load && w_full;
  assign w_consume   = w_pop;
  assign w_mem_we    = w_push;
  assign w_mem_wdata = load_ins;
`endif

  // Strobe decode as {Rd1, Rd2, Wr}
  always_comb begin
    w_dec = 3'b111;
    if (w_head[15:12] == 4'hD) begin
      w_dec = 3'b101;
    end else if (w_head[15:12] >= 4'hE) begin
      w_dec = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_mem_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_consume) begin
        r_count <= r_count + 5'd1;
      end else if (!w_push && w_consume) begin
        r_count <= r_count - 5'd1;
      end
      if (w_reject) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ins   <= 16'h0000;
      r_valid <= 1'b0;
      r_rd1   <= 1'b0;
      r_rd2   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_ins <= w_head;
            if (w_head[15:12] == 4'hF) begin
              r_state <= S_HALTED;
            end else begin
              r_state <= S_BUSY;
              r_valid <= 1'b1;
              {r_rd1, r_rd2, r_wr} <= w_dec;
            end
          end
        end
        S_BUSY: begin
          if (ack) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_rd1   <= 1'b0;
            r_rd2   <= 1'b0;
            r_wr    <= 1'b0;
          end
        end
        S_HALTED: begin
          if (!run) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ins_valid = r_valid;
  assign opcode    = r_ins[15:12];
  assign src1      = r_ins[11:8];
  assign src2      = r_ins[7:4];
  assign dest      = r_ins[3:0];
  assign Rd1       = r_rd1;
  assign Rd2       = r_rd2;
  assign Wr        = r_wr;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
